// File: rtl/clock_pkg.sv
// Shared encodings for the clock chip: edit-status codes used by the timekeeping
// core and the 7-segment glyph table used by the display scanner.
package clock_pkg;

    typedef enum logic [2:0] {
        STATUS_SHOW_TIME   = 3'd0,
        STATUS_SHOW_HOUR   = 3'd1,
        STATUS_SHOW_MINUTE = 3'd2,
        STATUS_SHOW_MONTH  = 3'd3,
        STATUS_SHOW_DAY    = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        CONV_LOAD,
        CONV_RUN,
        CONV_COMMIT,
        CONV_IDLE
    } conv_state_e;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/clock_display_scan_bcd.sv
// Sequential binary-to-BCD converter for a 6-bit field: subtracts 10 once per
// clock until the remainder is a single digit.
module bin_to_bcd_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    logic [5:0] r_rem;
    logic [2:0] r_tens;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_tens <= '0;
        end else if (start) begin
            r_rem  <= bin;
            r_tens <= '0;
        end else if (r_rem >= 6'd10) begin
            r_rem  <= r_rem - 6'd10;
            r_tens <= r_tens + 3'd1;
        end
    end

    assign tens = r_tens;
    assign ones = r_rem[3:0];
    assign done = (r_rem < 6'd10);

endmodule

// File: rtl/clock_display_scan.sv
// 4-digit multiplexed 7-segment scanner: snapshots a field pair once per frame,
// converts it to BCD, and drives segments/digit enables with edit-field blinking.
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV   = 32,
    parameter int BLINK_DIV  = 16384,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [2:0] status,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [2:0]    r_status_q;

    conv_state_e   r_state;
    conv_state_e   w_next_state;
    logic          w_start;
    logic          w_commit;
    logic [2:0]    r_snap_status;

    logic          r_valid;
    logic [2:0]    r_disp_status;
    logic [2:0]    r_disp_lt;
    logic [3:0]    r_disp_lo;
    logic [2:0]    r_disp_rt;
    logic [3:0]    r_disp_ro;

    logic          w_scan_wrap;
    logic          w_frame_start;
    logic          w_status_chg;
    logic          w_date;
    logic [5:0]    w_left_bin;
    logic [5:0]    w_right_bin;
    logic [2:0]    w_lt;
    logic [3:0]    w_lo;
    logic [2:0]    w_rt;
    logic [3:0]    w_ro;
    logic          w_left_done;
    logic          w_right_done;

    logic [3:0]    w_digit;
    logic          w_blink_grp;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [3:0]    w_en;

    assign w_scan_wrap   = (r_scan_cnt == SCAN_LAST);
    assign w_frame_start = w_scan_wrap && (r_idx == 2'd3);
    assign w_status_chg  = (status != r_status_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // A status change restarts the blink in its visible half so the newly
    // selected field shows up at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_status_q    <= '0;
        end else begin
            r_status_q <= status;
            if (w_status_chg) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_date      = (status == STATUS_SHOW_MONTH) || (status == STATUS_SHOW_DAY);
    assign w_left_bin  = w_date ? {2'b00, month} : {1'b0, hour};
    assign w_right_bin = w_date ? {1'b0, day}    : minute;

    bin_to_bcd_seq u_left (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .bin   (w_left_bin),
        .tens  (w_lt),
        .ones  (w_lo),
        .done  (w_left_done)
    );

    bin_to_bcd_seq u_right (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .bin   (w_right_bin),
        .tens  (w_rt),
        .ones  (w_ro),
        .done  (w_right_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= CONV_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            CONV_LOAD: begin
                w_start      = 1'b1;
                w_next_state = CONV_RUN;
            end
            CONV_RUN: begin
                if (w_left_done && w_right_done) w_next_state = CONV_COMMIT;
            end
            CONV_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = CONV_IDLE;
            end
            default: ;
        endcase
        if (w_frame_start) w_next_state = CONV_LOAD;
    end

    // Displayed digits only move at COMMIT, so a field pair is never torn.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snap_status <= '0;
            r_valid       <= 1'b0;
            r_disp_status <= '0;
            r_disp_lt     <= '0;
            r_disp_lo     <= '0;
            r_disp_rt     <= '0;
            r_disp_ro     <= '0;
        end else begin
            if (w_start) r_snap_status <= status;
            if (w_commit) begin
                r_valid       <= 1'b1;
                r_disp_status <= r_snap_status;
                r_disp_lt     <= w_lt;
                r_disp_lo     <= w_lo;
                r_disp_rt     <= w_rt;
                r_disp_ro     <= w_ro;
            end
        end
    end

    always_comb begin
        w_digit     = '0;
        w_blink_grp = 1'b0;
        w_seg       = SEG_BLANK;
        w_dp        = 1'b0;
        w_en        = '0;
        case (r_idx)
            2'd0:    w_digit = {1'b0, r_disp_lt};
            2'd1:    w_digit = r_disp_lo;
            2'd2:    w_digit = {1'b0, r_disp_rt};
            default: w_digit = r_disp_ro;
        endcase
        case (r_disp_status)
            STATUS_SHOW_TIME: begin
                w_dp = (r_idx == 2'd1) && r_blink_phase;
            end
            STATUS_SHOW_HOUR, STATUS_SHOW_MONTH: begin
                w_blink_grp = ~r_idx[1];
                w_dp        = (r_idx == 2'd1);
            end
            STATUS_SHOW_MINUTE, STATUS_SHOW_DAY: begin
                w_blink_grp = r_idx[1];
                w_dp        = (r_idx == 2'd1);
            end
            default: ;
        endcase
        if (r_disp_status > 3'd4) begin
            w_seg = SEG_DASH;
            w_dp  = 1'b0;
        end else if (w_blink_grp && !r_blink_phase) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = seg_of(w_digit);
        end
        if (!r_valid) begin
            w_seg = SEG_BLANK;
            w_dp  = 1'b0;
        end
        // Slot's first cycle keeps all digits off to hide segment ghosting.
        if (r_valid && (r_scan_cnt != '0)) w_en = 4'b1000 >> r_idx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg      <= {7{ACTIVE_LOW}};
            dp       <= ACTIVE_LOW;
            digit_en <= {4{ACTIVE_LOW}};
        end else begin
            seg      <= w_seg ^ {7{ACTIVE_LOW}};
            dp       <= w_dp ^ ACTIVE_LOW;
            digit_en <= w_en ^ {4{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: a frame-level reference model
// predicts every pin from elapsed cycles, frame snapshots and blink timing.
module tb_clock_display_scan;

    localparam int S  = 16;
    localparam int B  = 64;
    localparam int FR = 4 * S;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic [3:0] month = '0;
    logic [4:0] day = '0;
    logic [2:0] status = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_en;

    int checks = 0;
    int errors = 0;

    clock_display_scan #(
        .SCAN_DIV   (S),
        .BLINK_DIV  (B),
        .ACTIVE_LOW (1'b0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .hour     (hour),
        .minute   (minute),
        .month    (month),
        .day      (day),
        .status   (status),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st;
        int l;
        int r;
    } frame_t;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] en;
        bit         chk_en;
        bit         chk_seg;
    } exp_t;

    logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         k = 0;
    int         bstart = 0;
    int         snap_k = -100;
    logic [2:0] prev_st = '0;
    bit         ph = 1'b1;
    bit         pin_ph = 1'b1;
    frame_t     cur, nxt, pin_cur;

    // Model timebase: k counts clock edges since reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k = 0; bstart = 0; snap_k = -100; prev_st = '0; ph = 1'b1; pin_ph = 1'b1;
        end else begin
            pin_ph  = ph;
            pin_cur = cur;
            k = k + 1;
            if (status != prev_st) bstart = k;
            prev_st = status;
            ph = ((((k - bstart) / B) % 2) == 0);
            if ((k - 1) % FR == 0) begin
                nxt.st = int'(status);
                if (status == 3'd3 || status == 3'd4) begin
                    nxt.l = int'(month); nxt.r = int'(day);
                end else begin
                    nxt.l = int'(hour);  nxt.r = int'(minute);
                end
                snap_k = k;
            end
            if (k == snap_k + 8) cur = nxt;
        end
    end

    function automatic exp_t model_pins();
        exp_t e;
        int p, idx, sc, d;
        bit bl;
        p   = (k - 1) % FR;
        idx = p / S;
        sc  = p % S;
        e.chk_en  = (k >= 10);
        e.chk_seg = (k >= 10) && (p >= 9);
        e.en  = (sc != 0) ? (4'b1000 >> idx) : 4'b0000;
        case (idx)
            0:       d = pin_cur.l / 10;
            1:       d = pin_cur.l % 10;
            2:       d = pin_cur.r / 10;
            default: d = pin_cur.r % 10;
        endcase
        if (pin_cur.st >= 5) begin
            e.seg = 7'h40;
            e.dp  = 1'b0;
        end else begin
            bl = ((pin_cur.st == 1 || pin_cur.st == 3) && idx < 2) ||
                 ((pin_cur.st == 2 || pin_cur.st == 4) && idx >= 2);
            e.seg = (bl && !pin_ph) ? 7'h00 : SEGT[d];
            e.dp  = (idx == 1) ? ((pin_cur.st == 0) ? pin_ph : 1'b1) : 1'b0;
        end
        return e;
    endfunction

    task automatic set_fields(input int h, input int mi, input int mo, input int dy, input int st);
        @(negedge clock);
        hour = 5'(h); minute = 6'(mi); month = 4'(mo); day = 5'(dy); status = 3'(st);
    endtask

    task automatic test_reset();
        set_fields(9, 5, 1, 1, 0);
        repeat (3) @(negedge clock);
        checks += 3;
        if (seg !== 7'h00)      begin errors++; $display("FAIL reset_seg got %h exp 00", seg); end
        if (dp !== 1'b0)        begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
        if (digit_en !== 4'h0)  begin errors++; $display("FAIL reset_en got %b exp 0000", digit_en); end
        reset = 1'b1;
    endtask

    task automatic test_first_frame();
        exp_t e;
        repeat (3 * FR) begin
            @(negedge clock);
            e = model_pins();
            if (e.chk_en) begin
                checks++;
                if (digit_en !== e.en) begin errors++; $display("FAIL first_en k=%0d got %b exp %b", k, digit_en, e.en); end
            end
            if (e.chk_seg) begin
                checks += 2;
                if (seg !== e.seg) begin errors++; $display("FAIL first_seg k=%0d got %h exp %h", k, seg, e.seg); end
                if (dp !== e.dp)   begin errors++; $display("FAIL first_dp k=%0d got %b exp %b", k, dp, e.dp); end
            end
        end
    endtask

    task automatic test_max_time();
        exp_t e;
        set_fields(23, 59, 1, 1, 0);
        repeat (5 * FR) begin
            @(negedge clock);
            e = model_pins();
            if (e.chk_en) begin
                checks++;
                if (digit_en !== e.en) begin errors++; $display("FAIL max_en k=%0d got %b exp %b", k, digit_en, e.en); end
            end
            if (e.chk_seg) begin
                checks += 2;
                if (seg !== e.seg) begin errors++; $display("FAIL max_seg k=%0d got %h exp %h", k, seg, e.seg); end
                if (dp !== e.dp)   begin errors++; $display("FAIL max_dp k=%0d got %b exp %b", k, dp, e.dp); end
            end
        end
    endtask

    task automatic test_edit_blink();
        exp_t e;
        for (int s = 1; s <= 2; s++) begin
            set_fields(7, 42, 1, 1, s);
            repeat (5 * FR + 13) begin
                @(negedge clock);
                e = model_pins();
                if (e.chk_en) begin
                    checks++;
                    if (digit_en !== e.en) begin errors++; $display("FAIL blink_en k=%0d got %b exp %b", k, digit_en, e.en); end
                end
                if (e.chk_seg) begin
                    checks += 2;
                    if (seg !== e.seg) begin errors++; $display("FAIL blink_seg s=%0d k=%0d got %h exp %h", s, k, seg, e.seg); end
                    if (dp !== e.dp)   begin errors++; $display("FAIL blink_dp s=%0d k=%0d got %b exp %b", s, k, dp, e.dp); end
                end
            end
        end
    endtask

    task automatic test_date_and_invalid();
        exp_t e;
        for (int s = 3; s <= 6; s++) begin
            if (s == 5) continue;
            set_fields(23, 59, 12, 31, s);
            repeat (4 * FR) begin
                @(negedge clock);
                e = model_pins();
                if (e.chk_en) begin
                    checks++;
                    if (digit_en !== e.en) begin errors++; $display("FAIL date_en k=%0d got %b exp %b", k, digit_en, e.en); end
                end
                if (e.chk_seg) begin
                    checks += 2;
                    if (seg !== e.seg) begin errors++; $display("FAIL date_seg s=%0d k=%0d got %h exp %h", s, k, seg, e.seg); end
                    if (dp !== e.dp)   begin errors++; $display("FAIL date_dp s=%0d k=%0d got %b exp %b", s, k, dp, e.dp); end
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        exp_t e;
        int guard;
        set_fields(12, 59, 1, 1, 0);
        repeat (2 * FR) @(negedge clock);
        guard = 0;
        while (((k % FR) / S != 2) && guard < 2 * FR) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (guard >= 2 * FR) begin errors++; $display("FAIL mid_wait got timeout exp slot 2"); end
        minute = 6'd0;
        repeat (2 * FR) begin
            @(negedge clock);
            e = model_pins();
            if (e.chk_en) begin
                checks++;
                if (digit_en !== e.en) begin errors++; $display("FAIL mid_en k=%0d got %b exp %b", k, digit_en, e.en); end
            end
            if (e.chk_seg) begin
                checks += 2;
                if (seg !== e.seg) begin errors++; $display("FAIL mid_seg k=%0d got %h exp %h", k, seg, e.seg); end
                if (dp !== e.dp)   begin errors++; $display("FAIL mid_dp k=%0d got %b exp %b", k, dp, e.dp); end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        int st;
        for (int n = 0; n < 40; n++) begin
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            set_fields(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), st);
            repeat ($urandom_range(1, 90)) begin
                @(negedge clock);
                e = model_pins();
                if (e.chk_en) begin
                    checks++;
                    if (digit_en !== e.en) begin errors++; $display("FAIL rand_en k=%0d got %b exp %b", k, digit_en, e.en); end
                end
                if (e.chk_seg) begin
                    checks += 2;
                    if (seg !== e.seg) begin errors++; $display("FAIL rand_seg k=%0d got %h exp %h", k, seg, e.seg); end
                    if (dp !== e.dp)   begin errors++; $display("FAIL rand_dp k=%0d got %b exp %b", k, dp, e.dp); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int guard;
        set_fields(9, 5, 1, 1, 0);
        guard = 0;
        while (((k % FR) / S != 2) && guard < 2 * FR) begin
            @(negedge clock);
            guard++;
        end
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (guard >= 2 * FR)   begin errors++; $display("FAIL rstmid_wait got timeout exp slot 2"); end
        if (seg !== 7'h00)     begin errors++; $display("FAIL rstmid_seg got %h exp 00", seg); end
        if (dp !== 1'b0)       begin errors++; $display("FAIL rstmid_dp got %b exp 0", dp); end
        if (digit_en !== 4'h0) begin errors++; $display("FAIL rstmid_en got %b exp 0000", digit_en); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3 * FR) begin
            @(negedge clock);
            e = model_pins();
            if (e.chk_en) begin
                checks++;
                if (digit_en !== e.en) begin errors++; $display("FAIL resume_en k=%0d got %b exp %b", k, digit_en, e.en); end
            end
            if (e.chk_seg) begin
                checks += 2;
                if (seg !== e.seg) begin errors++; $display("FAIL resume_seg k=%0d got %h exp %h", k, seg, e.seg); end
                if (dp !== e.dp)   begin errors++; $display("FAIL resume_dp k=%0d got %b exp %b", k, dp, e.dp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_max_time();
        test_edit_blink();
        test_date_and_invalid();
        test_mid_frame();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Display-side counterpart of the timekeeping/key-input core.
- Consumes hour/minute/month/day fields and the edit status from the core.
- Converts two binary fields to BCD with a sequential subtract-10 converter and drives a 4-digit multiplexed 7-segment display.
- The field being edited blinks; the display pins are the chip outputs (seg+dp on uo_out, digit enables on uio).

Parameters:
- SCAN_DIV, 32: clock cycles per digit slot (32768 Hz / 32 / 4 = 256 Hz frame rate); must be ≥ 8.
- BLINK_DIV, 16384: cycles per blink half-period (0.5 s at 32768 Hz).
- ACTIVE_LOW, 0: 1 inverts seg, dp and digit_en at the output registers.

Ports:
- clock  in  1  system clock (32768 Hz nominal)
- reset  in  1  asynchronous, active-low
- hour  in  5  0..23
- minute  in  6  0..59
- month  in  4  1..12
- day  in  5  1..31
- status  in  3  0 time, 1 edit hour, 2 edit minute, 3 edit month, 4 edit day, 5..7 invalid
- seg  out  7  {g,f,e,d,c,b,a}, active-high when ACTIVE_LOW=0
- dp  out  1  decimal point of the current digit
- digit_en  out  4  one-hot; bit 3 = leftmost digit

Behaviour:
- Reset: seg=0, dp=0, digit_en=0 (all inverted if ACTIVE_LOW).
  - scan_cnt=0, idx=0, blink_phase=1 (visible), valid=0.
  - Converter FSM enters LOAD on the first clock after release.
- Scan: scan_cnt counts 0..SCAN_DIV-1. On wrap, idx advances 0→1→2→3→0.
  - idx 0 = leftmost digit; digit_en = 4'b1000 >> idx.
  - Ghost guard: digit_en=0 whenever scan_cnt==0.
  - Outputs are registered: 1-cycle latency from idx/scan_cnt to pins.
  - digit_en stays 0 while valid=0.
- Frame start: the scan_cnt wrap with idx==3 puts the FSM in LOAD.
- Converter FSM: LOAD → CONV → COMMIT → IDLE.
  - LOAD: snapshot status, left value and right value:
    - status 0/1/2: left=hour, right=minute.
    - status 3/4: left=month, right=day.
  - CONV: two bin_to_bcd_seq instances run in parallel. Each cycle, if rem ≥ 10 then rem −= 10 and tens += 1. Exit when both rem < 10. Worst case 5 iterations (59).
  - COMMIT: load the 4 displayed BCD digits and the snapshotted status; set valid=1.
  - Worst-case LOAD-to-COMMIT latency is 7 cycles, so conversion always finishes within one slot.
- Displayed digits change only at COMMIT. Input changes mid-frame are not visible until the next frame, so a field pair is never torn.
- Encoding: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; dash=40; blank=00.
  - Leading zeros are shown (09, 01).
- Per committed status:
  - 0: HH MM; dp on digit 1 = blink_phase (colon substitute).
  - 1: as 0, but digits 0–1 blank when blink_phase=0; dp on digit 1 steady 1.
  - 2: as 1, but digits 2–3 blink instead of 0–1.
  - 3: MM.DD; dp on digit 1 steady; digits 0–1 blink.
  - 4: MM.DD; dp on digit 1 steady; digits 2–3 blink.
  - 5..7: all digits dash (40), dp=0, no blink.
- Blink: blink_cnt counts 0..BLINK_DIV-1 and blink_phase toggles on wrap.
  - A registered status_q detects any change of the status input. On change, blink_cnt=0 and blink_phase=1 in that same cycle, so a newly selected field appears immediately.
- Out-of-range inputs (e.g. minute 63) are converted arithmetically; 63 → 6,3. No clamping.
- Async reset mid-frame: all outputs blank immediately, and the FSM restarts at LOAD after release.

Decomposition:
- clock_pkg holds:
  - STATUS_SHOW_TIME/HOUR/MINUTE/MONTH/DAY encodings, shared with the timekeeping core.
  - SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK constants.
- Sub-module bin_to_bcd_seq:
  - Ports: clock, reset, start, bin[5:0] → tens[2:0], ones[3:0], done.
  - Instantiated twice.
- Top level: scan counter, blink logic, FSM sequencing and output mux.

Test Plan:
- Reset release, status 0, hour=9, minute=5:
  - after the first COMMIT, slots show 3F,6F,3F,6D;
  - digit_en steps 1000,0100,0010,0001, each SCAN_DIV−1 cycles high after a 1-cycle gap.
- hour=23, minute=59:
  - COMMIT within 7 cycles of frame start;
  - digits 5B,4F,6D,6F; dp on digit 1 toggles every BLINK_DIV cycles.
- BLINK_DIV=64, status=1:
  - digits 0–1 read 00 during phase 0 while digits 2–3 stay lit;
  - switch to status 2: blink_phase=1 on the next cycle and digits 2–3 blink.
- status=3, month=12, day=31: display 06,5B,4F,06, with dp=1 on digit 1 while digits 0–1 are visible.
- status=6: all four slots 40, dp=0, no blinking.
- Change minute 59→0 while idx=2: current frame still shows 59; the next frame shows 00.
- Assert reset while idx=2: seg, dp and digit_en are 0 with no clock edge, and display resumes after a fresh COMMIT.
